// File: rtl/bound_flasher_pkg.sv
// Shared state/count encodings and sizing defaults for the bound flasher.
// Imported by both next_state_generator and the sequential datapath.
package bound_flasher_pkg;

  localparam int LED_NUM_DEF = 16;
  localparam int CNT_W_DEF   = 5;

  // Counter values at which a held flick kicks the sequence back
  localparam int KICK_HI_CNT = 5;
  localparam int KICK_LO_CNT = 0;

  typedef enum logic [2:0] {
    INIT_STATE       = 3'd0,
    ONLED0_15_STATE  = 3'd1,
    OFFLED15_5_STATE = 3'd2,
    ONLED5_10_STATE  = 3'd3,
    OFFLED10_0_STATE = 3'd4,
    ONLED0_5_STATE   = 3'd5,
    OFFLED5_0_STATE  = 3'd6
  } main_state_e;

  typedef enum logic [1:0] {
    COUNT_DIS     = 2'b00,
    COUNT_UP_EN   = 2'b01,
    COUNT_DOWN_EN = 2'b10
  } count_state_e;

endpackage

// File: rtl/flasher_state_datapath_if.sv
// Generator <-> datapath bundle; master = next_state_generator side, slave = datapath.
// All signals are plain per-cycle levels, no handshake or backpressure.
interface flasher_if
  import bound_flasher_pkg::*;
#(
  parameter int LED_NUM = LED_NUM_DEF,
  parameter int CNT_W   = CNT_W_DEF
) ();

  logic               flick_in;
  logic [2:0]         main_state_n;
  logic [CNT_W-1:0]   counter_load;
  logic               counter_load_en;
  logic [1:0]         count_state;

  logic [2:0]         main_state;
  logic [CNT_W-1:0]   counter;
  logic               flick;
  logic               kickback_match;
  logic [LED_NUM-1:0] led;

  modport master (
    output flick_in, main_state_n, counter_load, counter_load_en, count_state,
    input  main_state, counter, flick, kickback_match, led
  );

  modport slave (
    input  flick_in, main_state_n, counter_load, counter_load_en, count_state,
    output main_state, counter, flick, kickback_match, led
  );

endinterface

// File: rtl/flasher_state_datapath_led_counter.sv
// Saturating load/up/down lamp counter with registered thermometer LED vector.
// Latency 1 clk from controls to counter and led; no backpressure.
module led_counter
  import bound_flasher_pkg::*;
#(
  parameter int LED_NUM = LED_NUM_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CNT_W-1:0]   load_i,
  input  logic               load_en_i,
  input  logic [1:0]         count_state_i,
  output logic [CNT_W-1:0]   counter_o,
  output logic [LED_NUM-1:0] led_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LED_NUM);

  logic [CNT_W-1:0]   counter_q, counter_d;
  logic [LED_NUM-1:0] led_q, led_d;

  always_comb begin
    counter_d = counter_q;
    if (load_en_i) begin
      counter_d = (load_i > CNT_MAX) ? CNT_MAX : load_i;
    end else begin
      case (count_state_i)
        COUNT_UP_EN: begin
          if (counter_q < CNT_MAX) counter_d = counter_q + CNT_W'(1);
        end
        COUNT_DOWN_EN: begin
          if (counter_q != '0) counter_d = counter_q - CNT_W'(1);
        end
        default: counter_d = counter_q;
      endcase
    end
  end

  // led is built from counter_d so it never lags the counter by a cycle
  always_comb begin
    led_d = '0;
    for (int i = 0; i < LED_NUM; i++) begin
      led_d[i] = (CNT_W'(i) < counter_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter_q <= '0;
      led_q     <= '0;
    end else begin
      counter_q <= counter_d;
      led_q     <= led_d;
    end
  end

  assign counter_o = counter_q;
  assign led_o     = led_q;

endmodule

// File: rtl/flasher_state_datapath.sv
// Clocked half of the bound flasher: state register, flick conditioning, lamp counter.
// Latency 1 clk state/counter (flick +2 clk with FLICK_SYNC_EN); no backpressure.
module flasher_state_datapath
  import bound_flasher_pkg::*;
#(
  parameter int LED_NUM = LED_NUM_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input logic    clk,
  input logic    rst,
  flasher_if.slave bus
);

  logic [2:0]         main_state_q, main_state_d;
  logic               flick_w;
  logic               kick_hit;
  logic [CNT_W-1:0]   counter_w;
  logic [LED_NUM-1:0] led_w;

  // Illegal codes pass through; the generator is responsible for recovery
  assign main_state_d = bus.main_state_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) main_state_q <= INIT_STATE;
    else     main_state_q <= main_state_d;
  end

`ifdef FLICK_SYNC_EN
  logic [1:0] sync_q, sync_d;

  assign sync_d = {sync_q[0], bus.flick_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign flick_w = sync_q[1];
`else
  assign flick_w = bus.flick_in;
`endif

  led_counter #(
    .LED_NUM (LED_NUM),
    .CNT_W   (CNT_W)
  ) u_led_counter (
    .clk           (clk),
    .rst           (rst),
    .load_i        (bus.counter_load),
    .load_en_i     (bus.counter_load_en),
    .count_state_i (bus.count_state),
    .counter_o     (counter_w),
    .led_o         (led_w)
  );

  always_comb begin
    kick_hit = 1'b0;
    if (main_state_q == OFFLED15_5_STATE && counter_w == CNT_W'(KICK_HI_CNT)) kick_hit = 1'b1;
    if (main_state_q == OFFLED10_0_STATE && counter_w == CNT_W'(KICK_LO_CNT)) kick_hit = 1'b1;
  end

  assign bus.main_state     = main_state_q;
  assign bus.counter        = counter_w;
  assign bus.led            = led_w;
  assign bus.flick          = flick_w;
  assign bus.kickback_match = flick_w & kick_hit;

endmodule
